// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: EX/MEM/WB write scoreboard, forward selects,
// load-use stalls and redirect flushes. Optional perf counters under `HAZARD_CNT_EN.
module hazard_ctrl #(
   parameter int REG_AW          = 5,
   parameter int LU_STALL_CYCLES = 1
`ifdef HAZARD_CNT_EN
   ,
   parameter int CNT_W           = 32
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rR1,
   input  logic [REG_AW-1:0] id_rR2,
   input  logic              id_rR1_used,
   input  logic              id_rR2_used,
   input  logic              id_rf_we,
   input  logic [1:0]        id_rf_wsel,
   input  logic [REG_AW-1:0] id_wR,
   input  logic              ex_redirect,
   output logic [2:0]        rR1_forward,
   output logic [2:0]        rR2_forward,
   output logic              pc_stall,
   output logic              if_id_stall,
   output logic              if_id_flush,
   output logic              id_ex_flush,
   output logic              stall_busy
`ifdef HAZARD_CNT_EN
   ,
   output logic [CNT_W-1:0]  lu_stall_cnt,
   output logic [CNT_W-1:0]  redirect_cnt
`endif
);

   localparam int CW = (LU_STALL_CYCLES > 1) ? $clog2(LU_STALL_CYCLES) : 1;
   localparam logic [1:0] WSEL_LOAD = 2'd3;

   typedef struct packed {
      logic              vld;
      logic              we;
      logic [1:0]        wsel;
      logic [REG_AW-1:0] wr;
   } slot_t;

   typedef enum logic {RUN = 1'b0, STALL = 1'b1} state_t;

   slot_t   ex_q, mem_q, wb_q, ex_d;
   state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic    lu_hit, lu_take;
   logic    ex1, mem1, wb1, ex2, mem2, wb2;

   function automatic logic hit(input slot_t sl, input logic [REG_AW-1:0] s,
                                input logic used, input logic v);
      return v & used & (s != '0) & sl.vld & sl.we & (sl.wr == s);
   endfunction

   // A load in EX cannot forward yet; that case is resolved by the stall, so code 0.
   function automatic logic [2:0] fwd(input logic e, input logic m, input logic w,
                                      input logic [1:0] ewsel, input logic [1:0] mwsel);
      if (e)      return (ewsel != WSEL_LOAD) ? 3'd1 : 3'd0;
      else if (m) return (mwsel == WSEL_LOAD) ? 3'd4 : 3'd2;
      else if (w) return 3'd3;
      else        return 3'd0;
   endfunction

   always_comb begin
      ex1  = hit(ex_q,  id_rR1, id_rR1_used, id_valid);
      mem1 = hit(mem_q, id_rR1, id_rR1_used, id_valid);
      wb1  = hit(wb_q,  id_rR1, id_rR1_used, id_valid);
      ex2  = hit(ex_q,  id_rR2, id_rR2_used, id_valid);
      mem2 = hit(mem_q, id_rR2, id_rR2_used, id_valid);
      wb2  = hit(wb_q,  id_rR2, id_rR2_used, id_valid);
      rR1_forward = fwd(ex1, mem1, wb1, ex_q.wsel, mem_q.wsel);
      rR2_forward = fwd(ex2, mem2, wb2, ex_q.wsel, mem_q.wsel);
      lu_hit = (ex1 | ex2) & (ex_q.wsel == WSEL_LOAD);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_stall    = 1'b0;
      if_id_stall = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      lu_take     = 1'b0;
      if (ex_redirect) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
         state_d     = RUN;
         cnt_d       = '0;
      end else begin
         case (state_q)
            RUN: begin
               if (lu_hit) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
                  lu_take     = 1'b1;
                  state_d     = STALL;
                  cnt_d       = CW'(LU_STALL_CYCLES - 1);
               end
            end
            STALL: begin
               if (cnt_q != '0) begin
                  pc_stall    = 1'b1;
                  if_id_stall = 1'b1;
                  id_ex_flush = 1'b1;
                  cnt_d       = cnt_q - 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
      stall_busy = (state_q == STALL);
      ex_d = id_ex_flush ? '0 : {id_valid, id_rf_we, id_rf_wsel, id_wR};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         wb_q    <= mem_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_CNT_EN
   logic [CNT_W-1:0] lu_cnt_q, rd_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_cnt_q <= '0;
         rd_cnt_q <= '0;
      end else begin
         if (stall_busy | lu_take) lu_cnt_q <= lu_cnt_q + 1'b1;
         if (ex_redirect)          rd_cnt_q <= rd_cnt_q + 1'b1;
      end
   end

   assign lu_stall_cnt = lu_cnt_q;
   assign redirect_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (default build): forwarding distances, load-use stall,
// redirect priority, x0, id_valid=0 and reset during a stall.
module tb_hazard_ctrl;

   logic       clk;
   logic       rst_n;
   logic       id_valid;
   logic [4:0] id_rR1, id_rR2, id_wR;
   logic       id_rR1_used, id_rR2_used, id_rf_we;
   logic [1:0] id_rf_wsel;
   logic       ex_redirect;
   logic [2:0] rR1_forward, rR2_forward;
   logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush, stall_busy;

   int checks = 0;
   int errors = 0;

   hazard_ctrl dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rR1(id_rR1), .id_rR2(id_rR2),
      .id_rR1_used(id_rR1_used), .id_rR2_used(id_rR2_used),
      .id_rf_we(id_rf_we), .id_rf_wsel(id_rf_wsel), .id_wR(id_wR),
      .ex_redirect(ex_redirect),
      .rR1_forward(rR1_forward), .rR2_forward(rR2_forward),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .stall_busy(stall_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                         input logic u1, input logic u2, input logic we,
                         input logic [1:0] ws, input logic [4:0] wr, input logic rd);
      id_valid    = v;
      id_rR1      = r1;
      id_rR2      = r2;
      id_rR1_used = u1;
      id_rR2_used = u2;
      id_rf_we    = we;
      id_rf_wsel  = ws;
      id_wR       = wr;
      ex_redirect = rd;
      #2;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Packs the five control outputs: {pc_stall, if_id_stall, if_id_flush, id_ex_flush, stall_busy}
   function automatic logic [7:0] ctl();
      return {3'b000, pc_stall, if_id_stall, if_id_flush, id_ex_flush, stall_busy};
   endfunction

   initial begin
      rst_n = 1'b0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("reset_fwd1", rR1_forward, 0);
      chk("reset_fwd2", rR2_forward, 0);
      chk("reset_ctl", ctl(), 8'b00000);
      rst_n = 1'b1;
      cyc();

      // ALU write x5, immediate reader -> EX forward
      set_id(1, 0, 0, 0, 0, 1, 2, 5, 0);
      cyc();
      set_id(1, 5, 0, 1, 0, 0, 2, 0, 0);
      chk("ex_fwd1", rR1_forward, 1);
      chk("ex_noctl", ctl(), 8'b00000);
      cyc();

      // ALU write x7, one unrelated, reader as rR2 -> MEM forward
      set_id(1, 0, 0, 0, 0, 1, 2, 7, 0);
      cyc();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      set_id(1, 0, 7, 0, 1, 0, 0, 0, 0);
      chk("mem_fwd2", rR2_forward, 2);
      chk("mem_fwd1_idle", rR1_forward, 0);
      cyc();

      // ALU write x9, two unrelated, reader -> WB; one more gap -> regfile
      set_id(1, 0, 0, 0, 0, 1, 2, 9, 0);
      cyc();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc();
      cyc();
      set_id(1, 9, 0, 1, 0, 0, 0, 0, 0);
      chk("wb_fwd1", rR1_forward, 3);
      cyc();
      set_id(1, 9, 0, 1, 0, 0, 0, 0, 0);
      chk("gone_fwd1", rR1_forward, 0);
      cyc();

      // Load x4 then reader of x4: one stall cycle, then code 4
      set_id(1, 0, 0, 0, 0, 1, 3, 4, 0);
      cyc();
      set_id(1, 4, 0, 1, 0, 0, 2, 0, 0);
      chk("lu_ctl", ctl(), 8'b11010);
      cyc();
      set_id(1, 4, 0, 1, 0, 0, 2, 0, 0);
      chk("lu_rel_fwd1", rR1_forward, 4);
      chk("lu_rel_ctl", ctl(), 8'b00001);
      cyc();
      set_id(1, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("lu_run_ctl", ctl(), 8'b00000);
      cyc();

      // Load x6 then reader with simultaneous redirect: flush wins, no stall
      set_id(1, 0, 0, 0, 0, 1, 3, 6, 0);
      cyc();
      set_id(1, 0, 6, 0, 1, 0, 0, 0, 1);
      chk("redir_ctl", ctl(), 8'b00110);
      cyc();
      set_id(1, 0, 6, 0, 1, 0, 0, 0, 0);
      chk("redir_after_ctl", ctl(), 8'b00000);
      chk("redir_after_fwd2", rR2_forward, 4);
      cyc();

      // x0 is never forwarded
      set_id(1, 0, 0, 0, 0, 1, 2, 0, 0);
      cyc();
      set_id(1, 0, 0, 1, 1, 0, 0, 0, 0);
      chk("x0_fwd1", rR1_forward, 0);
      chk("x0_fwd2", rR2_forward, 0);
      cyc();

      // id_valid=0 suppresses matches, even against a load
      set_id(1, 0, 0, 0, 0, 1, 3, 3, 0);
      cyc();
      set_id(0, 3, 3, 1, 1, 0, 0, 0, 0);
      chk("inv_fwd1", rR1_forward, 0);
      chk("inv_ctl", ctl(), 8'b00000);
      cyc();

      // Two writers of x2 back-to-back: youngest (EX) wins
      set_id(1, 0, 0, 0, 0, 1, 2, 2, 0);
      cyc();
      set_id(1, 0, 0, 0, 0, 1, 1, 2, 0);
      cyc();
      set_id(1, 2, 2, 1, 1, 0, 0, 0, 0);
      chk("prio_fwd1", rR1_forward, 1);
      chk("prio_fwd2", rR2_forward, 1);
      cyc();

      // Reset while in STALL
      set_id(1, 0, 0, 0, 0, 1, 3, 8, 0);
      cyc();
      set_id(1, 8, 0, 1, 0, 0, 0, 0, 0);
      chk("rst_lu_ctl", ctl(), 8'b11010);
      cyc();
      chk("rst_pre_busy", ctl(), 8'b00001);
      rst_n = 1'b0;
      #2;
      chk("rst_mid_ctl", ctl(), 8'b00000);
      chk("rst_mid_fwd1", rR1_forward, 0);
      rst_n = 1'b1;
      cyc();
      chk("rst_post_fwd1", rR1_forward, 0);
      chk("rst_post_ctl", ctl(), 8'b00000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
